// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// default geometry and the width helper for the operand feed index.
package systolic_pkg;

   localparam int DEFAULT_DIM       = 3;
   localparam int DEFAULT_DRAIN_CYC = DEFAULT_DIM;

   // Drain counter is sized for the largest allowed drain length (16 cycles).
   localparam int DRAIN_CNT_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      RESULT
   } state_e;

   // The feed index runs 0..2*dim-2, so this many bits always hold it.
   function automatic int feedWidth(input int dim);
      return $clog2(2 * dim);
   endfunction

endpackage

// File: rtl/systolic_lane_decode.sv
// Maps the operand feed index onto the per-lane valid window. Lane k is live
// for DIM consecutive feed steps starting at step k, which produces the
// diagonal skew the systolic grid needs. Kept separate so the operand feeder
// can reuse exactly the same window.
module systolic_lane_decode
   import systolic_pkg::*;
#(
   parameter int DIM = DEFAULT_DIM,
   parameter int CW  = feedWidth(DIM)
) (
   input  logic [CW-1:0]  feedCnt_i,
   input  logic           feedValid_i,
   output logic [DIM-1:0] laneEn_o
);

   // Lane k is active while feedCnt_i lies in the window [k, k+DIM-1].
   always_comb begin
      laneEn_o = '0;
      for (int k = 0; k < DIM; k++) begin
         if (feedValid_i && (int'(feedCnt_i) >= k) && (int'(feedCnt_i) <= k + DIM - 1)) begin
            laneEn_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Control sequencer for a DIMxDIM output-stationary systolic matrix multiply.
// A run clears the accumulators, feeds skewed operands for 2*DIM-1 cycles,
// lets the pipeline drain, then holds the results until the consumer takes
// them. Every output is decoded from registered state only, so nothing on
// start/abort/res_ready reaches an output combinationally.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int DIM       = DEFAULT_DIM,
   parameter int DRAIN_CYC = DIM
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      acc_clr,
   output logic                      acc_en,
   output logic [feedWidth(DIM)-1:0] feed_cnt,
   output logic [DIM-1:0]            lane_en,
   output logic                      res_valid,
   input  logic                      res_ready
);

   localparam int CW = feedWidth(DIM);
   localparam logic [CW-1:0]          FEED_LAST  = CW'(2 * DIM - 2);
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYC - 1);

   state_e                   state_q, state_d;
   logic [CW-1:0]            feedCnt_q, feedCnt_d;
   logic [DRAIN_CNT_W-1:0]   drainCnt_q, drainCnt_d;
   logic                     inFeed;

   // State and counter registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         feedCnt_q  <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         feedCnt_q  <= feedCnt_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Next-state logic; abort overrides every other transition, and start is
   // only honoured from IDLE or on the result handshake cycle.
   always_comb begin
      state_d    = state_q;
      feedCnt_d  = feedCnt_q;
      drainCnt_d = drainCnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d   = FEED;
            feedCnt_d = '0;
         end
         FEED: begin
            if (feedCnt_q == FEED_LAST) begin
               state_d    = DRAIN;
               feedCnt_d  = '0;
               drainCnt_d = '0;
            end else begin
               feedCnt_d = feedCnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drainCnt_q == DRAIN_LAST) begin
               state_d    = RESULT;
               drainCnt_d = '0;
            end else begin
               drainCnt_d = drainCnt_q + 1'b1;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_d = start ? CLEAR : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d    = IDLE;
         feedCnt_d  = '0;
         drainCnt_d = '0;
      end
   end

   assign inFeed    = (state_q == FEED);
   assign busy      = (state_q != IDLE);
   assign acc_clr   = (state_q == CLEAR);
   assign acc_en    = inFeed || (state_q == DRAIN);
   assign feed_cnt  = inFeed ? feedCnt_q : '0;
   assign res_valid = (state_q == RESULT);

   systolic_lane_decode #(
      .DIM (DIM),
      .CW  (CW)
   ) u_laneDecode (
      .feedCnt_i   (feed_cnt),
      .feedValid_i (inFeed),
      .laneEn_o    (lane_en)
   );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer at DIM=3, DRAIN_CYC=3. A table of
// per-cycle inputs and expected outputs covers the nominal run, back-pressure,
// back-to-back runs and abort; hand-written sequences cover start-while-busy,
// latency and asynchronous reset.
module tb_systolic_sequencer;

   localparam int DIM = 3;

   logic           clock;
   logic           reset;
   logic           start;
   logic           abort;
   logic           resReady;
   logic           busy;
   logic           accClr;
   logic           accEn;
   logic [2:0]     feedCnt;
   logic [DIM-1:0] laneEn;
   logic           resValid;

   int checkCount;
   int passCount;

   typedef struct {
      string      name;
      logic       start;
      logic       abort;
      logic       ready;
      logic [9:0] expOut;
   } vec_t;

   vec_t vecs[$];

   systolic_sequencer #(
      .DIM       (DIM),
      .DRAIN_CYC (3)
   ) dut (
      .clk       (clock),
      .rst       (reset),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .acc_clr   (accClr),
      .acc_en    (accEn),
      .feed_cnt  (feedCnt),
      .lane_en   (laneEn),
      .res_valid (resValid),
      .res_ready (resReady)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [9:0] packOut(input logic b, input logic c, input logic e,
                                          input int f, input logic [2:0] l, input logic v);
      return {b, c, e, 3'(f), l, v};
   endfunction

   function automatic logic [9:0] actualOut();
      return {busy, accClr, accEn, feedCnt, laneEn, resValid};
   endfunction

   task automatic addVec(input string n, input logic s, input logic a, input logic r,
                         input logic [9:0] e);
      vec_t v;
      v.name   = n;
      v.start  = s;
      v.abort  = a;
      v.ready  = r;
      v.expOut = e;
      vecs.push_back(v);
   endtask

   // Drive inputs on the falling edge, then step past the next rising edge.
   task automatic applyStimulus(input logic s, input logic a, input logic r);
      @(negedge clock);
      start    = s;
      abort    = a;
      resReady = r;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string n, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", n, actual, expected);
      end
   endtask

   // Appends one full run from a start cycle through the RESULT entry.
   task automatic addRun(input string tag);
      addVec({tag, "_clear"}, 1, 0, 0, packOut(1, 1, 0, 0, 3'b000, 0));
      addVec({tag, "_feed0"}, 0, 0, 0, packOut(1, 0, 1, 0, 3'b001, 0));
      addVec({tag, "_feed1"}, 0, 0, 0, packOut(1, 0, 1, 1, 3'b011, 0));
      addVec({tag, "_feed2"}, 0, 0, 0, packOut(1, 0, 1, 2, 3'b111, 0));
      addVec({tag, "_feed3"}, 0, 0, 0, packOut(1, 0, 1, 3, 3'b110, 0));
      addVec({tag, "_feed4"}, 0, 0, 0, packOut(1, 0, 1, 4, 3'b100, 0));
      for (int i = 0; i < 3; i++) begin
         addVec({tag, "_drain"}, 0, 0, 0, packOut(1, 0, 1, 0, 3'b000, 0));
      end
      addVec({tag, "_result"}, 0, 0, 0, packOut(1, 0, 0, 0, 3'b000, 1));
   endtask

   initial begin
      int m;
      int validCount;
      int clrCount;
      int firstValid;

      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      start      = 1'b1;
      abort      = 1'b0;
      resReady   = 1'b0;

      // Start held high while reset is asserted must not launch a run.
      @(posedge clock);
      #1;
      checkOutput("reset_state", int'(actualOut()), 0);
      @(posedge clock);
      #1;
      checkOutput("start_during_reset", int'(actualOut()), 0);
      @(negedge clock);
      start = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("idle_after_reset", int'(actualOut()), 0);

      // Nominal run followed by five cycles of back-pressure, then release.
      addRun("nom");
      for (int i = 0; i < 4; i++) begin
         addVec("backpressure", 0, 0, 0, packOut(1, 0, 0, 0, 3'b000, 1));
      end
      addVec("handshake_idle", 0, 0, 1, packOut(0, 0, 0, 0, 3'b000, 0));
      addVec("idle_hold",      0, 0, 0, packOut(0, 0, 0, 0, 3'b000, 0));

      // Back-to-back: start with the handshake goes straight to CLEAR.
      addRun("b2b");
      addVec("b2b_reclear", 1, 0, 1, packOut(1, 1, 0, 0, 3'b000, 0));
      addVec("b2b_feed0",   0, 0, 0, packOut(1, 0, 1, 0, 3'b001, 0));
      addVec("b2b_feed1",   0, 0, 0, packOut(1, 0, 1, 1, 3'b011, 0));
      addVec("b2b_feed2",   0, 0, 0, packOut(1, 0, 1, 2, 3'b111, 0));

      // Abort at feed_cnt=2 beats a simultaneous start; then a fresh run.
      addVec("abort_feed", 1, 1, 0, packOut(0, 0, 0, 0, 3'b000, 0));
      addRun("post_abort");
      addVec("abort_over_handshake", 1, 1, 1, packOut(0, 0, 0, 0, 3'b000, 0));
      addVec("idle_final", 0, 0, 0, packOut(0, 0, 0, 0, 3'b000, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].ready);
         checkOutput(vecs[i].name, int'(actualOut()), int'(vecs[i].expOut));
      end

      // Start pulses during FEED and DRAIN are ignored; exactly one result.
      applyStimulus(1, 0, 1);
      checkOutput("busy_start_clear", int'(accClr), 1);
      validCount = 0;
      clrCount   = 0;
      firstValid = 0;
      for (m = 1; m <= 30; m++) begin
         applyStimulus((m == 3) || (m == 8), 0, 1);
         if (accClr) clrCount++;
         if (resValid) begin
            validCount++;
            if (firstValid == 0) firstValid = m;
         end
      end
      checkOutput("first_run_latency", firstValid, 9);
      checkOutput("single_result", validCount, 1);
      checkOutput("no_extra_clear", clrCount, 0);
      checkOutput("idle_after_single", int'(busy), 0);

      // Asynchronous reset asserted between edges while in DRAIN.
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0);
      end
      checkOutput("in_drain", int'(actualOut()), int'(packOut(1, 0, 1, 0, 3'b000, 0)));
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_outputs", int'(actualOut()), 0);
      @(posedge clock);
      #1;
      checkOutput("reset_held", int'(actualOut()), 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1, 0, 0);
      checkOutput("restart_after_reset", int'(actualOut()), int'(packOut(1, 1, 0, 0, 3'b000, 0)));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 3, meaning array dimension (rows of A, columns of B, PE grid side); legal range 2..8.
REQ-002 SHALL have parameter DRAIN_CYC, default DIM, meaning cycles allowed for the last operands to propagate through the PE grid after feeding ends; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit, meaning a request to run one DIMxDIM matrix product.
REQ-006 SHALL have port abort, input, 1 bit, meaning cancel any run in progress.
REQ-007 SHALL have port busy, output, 1 bit, meaning state is not IDLE.
REQ-008 SHALL have port acc_clr, output, 1 bit, meaning clear all PE accumulators.
REQ-009 SHALL have port acc_en, output, 1 bit, meaning PEs multiply-accumulate this cycle.
REQ-010 SHALL have port feed_cnt, output, $clog2(2*DIM) bits, meaning the operand feed index that drives the skewed row/column feeder.
REQ-011 SHALL have port lane_en, output, DIM bits, meaning bit k is set when row k of A and column k of B carry valid data.
REQ-012 SHALL have port res_valid, output, 1 bit, meaning accumulator results are final.
REQ-013 SHALL have port res_ready, input, 1 bit, meaning the consumer accepts the results.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN and RESULT.
REQ-015 SHALL go IDLE->CLEAR on start=1; acc_clr=1 only in CLEAR, which lasts exactly 1 cycle, then FEED.
REQ-016 SHALL make FEED last 2*DIM-1 cycles, with feed_cnt 0,1,...,2*DIM-2 and acc_en=1; then DRAIN.
REQ-017 SHALL, in FEED, make lane_en[k] = (feed_cnt>=k && feed_cnt<=k+DIM-1): a skew of k cycles for lane k.
REQ-018 SHALL make DRAIN last DRAIN_CYC cycles with acc_en=1, lane_en=0 and feed_cnt held at 0; then RESULT.
REQ-019 SHALL hold res_valid=1 in RESULT until res_valid&&res_ready; handshake cycle -> IDLE, or -> CLEAR if start=1 in the same cycle (back-to-back run).
REQ-020 SHALL ignore start in CLEAR, FEED and DRAIN; no queueing of start.
REQ-021 SHALL go to IDLE on the next edge when abort=1 in any state, with abort taking priority over start and over the res handshake.
REQ-022 SHALL keep acc_en, lane_en and feed_cnt at 0 outside FEED/DRAIN, as stated above; all outputs are registered (no combinational path from start/abort/res_ready to any output).
REQ-023 SHALL give a first run a latency from the start edge to res_valid of 1+(2*DIM-1)+DRAIN_CYC cycles (DIM=3, DRAIN_CYC=3: 9 cycles).

Reset
REQ-024 SHALL, on rst=1, immediately force state=IDLE, busy=0, acc_clr=0, acc_en=0, feed_cnt=0, lane_en=0 and res_valid=0, including mid-run.
REQ-025 SHALL accept no start in the first edge after rst deasserts if rst is still high at that edge.

Structure
REQ-026 SHALL keep the state enum, the DIM/DRAIN_CYC defaults and the feed-count width function in shared package systolic_pkg.
REQ-027 SHALL place the lane-window decode (feed_cnt -> lane_en) in sub-module systolic_lane_decode, reusable by the operand feeder.

Verification
REQ-028 SHALL cover a nominal run: DIM=3, start 1 cycle -> acc_clr at cycle 1; feed_cnt 0..4 in cycles 2-6; lane_en 001,011,111,110,100; DRAIN in cycles 7-9; res_valid from cycle 10.
REQ-029 SHALL cover back-pressure: res_ready=0 for 5 cycles -> res_valid held, busy=1, acc_en=0; res_ready=1 -> IDLE next cycle.
REQ-030 SHALL cover back-to-back runs: start=1 with res_ready=1 in RESULT -> CLEAR next cycle and acc_clr pulses again, with no IDLE cycle.
REQ-031 SHALL cover abort: abort at feed_cnt=2 -> IDLE next edge, all outputs 0; a new start then runs a full nominal sequence.
REQ-032 SHALL cover start while busy: start pulses in FEED and DRAIN -> no effect, and exactly one RESULT occurs.
REQ-033 SHALL cover asynchronous reset: rst asserted mid-DRAIN between clock edges -> outputs reach reset values before the next edge.
